// File: rtl/uart_rx_fifo_if.sv
// Read-side port of the UART receive FIFO: head word, valid/ready handshake and fill level.
// The receiver drives the master side; the consumer attaches to the slave side.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [LEVEL_W-1:0]   fifo_level;

    modport master (
        output rd_data,
        output rd_valid,
        output fifo_level,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  fifo_level,
        output rd_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (configurable width, parity, stop bits, runtime divisor)
// feeding a small receive FIFO with a valid/ready read port and sticky error flags.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 rx,
    uart_rx_fifo_if.master       rd,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clear
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Receiver state
    logic                 rx_meta;
    logic                 rx_s;
    state_t               state;
    state_t               state_nx;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_nx;
    logic [BIT_W-1:0]     bit_idx;
    logic [BIT_W-1:0]     bit_idx_nx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nx;
    logic                 par_bad;
    logic                 par_bad_nx;
    logic                 frm_bad;
    logic                 frm_bad_nx;
    logic                 sample;
    logic                 frame_done;
    logic                 done_frame_bad;
    logic                 done_parity_bad;
    logic                 push_req;

    // FIFO state
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LEVEL_W-1:0]   level;
    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic                 drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
            frm_bad <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
            par_bad <= par_bad_nx;
            frm_bad <= frm_bad_nx;
        end
    end

    assign sample = (state != IDLE) && (cnt == '0);

    // Every non-idle state runs the same down-counter; state-specific work happens only on a sample.
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        bit_idx_nx      = bit_idx;
        shreg_nx        = shreg;
        par_bad_nx      = par_bad;
        frm_bad_nx      = frm_bad;
        frame_done      = 1'b0;
        done_frame_bad  = 1'b0;
        done_parity_bad = 1'b0;

        if (state == IDLE) begin
            if (!rx_s) begin
                cnt_nx     = (cfg_div >> 1) - DIV_WIDTH'(1);
                bit_idx_nx = '0;
                par_bad_nx = 1'b0;
                frm_bad_nx = 1'b0;
                state_nx   = START;
            end
        end else if (!sample) begin
            cnt_nx = cnt - DIV_WIDTH'(1);
        end else begin
            cnt_nx = cfg_div - DIV_WIDTH'(1);
            case (state)
                START: begin
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        bit_idx_nx = '0;
                        state_nx   = DATA;
                    end
                end
                DATA: begin
                    shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        bit_idx_nx = '0;
                        state_nx   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_nx = bit_idx + BIT_W'(1);
                    end
                end
                PARITY: begin
                    if (rx_s != ((^shreg) ^ (PARITY_ODD != 0))) begin
                        par_bad_nx = 1'b1;
                    end
                    bit_idx_nx = '0;
                    state_nx   = STOP;
                end
                STOP: begin
                    if (!rx_s) begin
                        frm_bad_nx = 1'b1;
                    end
                    if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                        frame_done      = 1'b1;
                        done_frame_bad  = frm_bad | ~rx_s;
                        done_parity_bad = par_bad;
                        state_nx        = IDLE;
                    end else begin
                        bit_idx_nx = bit_idx + BIT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign push_req = frame_done & ~done_frame_bad & ~done_parity_bad;

    // A full FIFO still takes a word when the consumer frees a slot in the same cycle.
    assign pop     = rd.rd_valid & rd.rd_ready;
    assign full    = (level == LEVEL_W'(FIFO_DEPTH));
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & ~push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                level <= level + LEVEL_W'(1);
            end else if (pop && !push_ok) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

    assign rd.rd_valid   = (level != '0);
    assign rd.rd_data    = rd.rd_valid ? mem[rd_ptr] : '0;
    assign rd.fifo_level = level;

    // A new error event takes priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done_frame_bad) begin
                frame_err <= 1'b1;
            end else if (err_clear) begin
                frame_err <= 1'b0;
            end
            if (done_parity_bad) begin
                parity_err <= 1'b1;
            end else if (err_clear) begin
                parity_err <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (err_clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
